// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared definitions for the multi-cycle MIPS control unit.
//   - state_t    : FSM state encodings (fits in 4 bits)
//   - OP_*       : instruction opcode field values
//   - ALU_B_*, ALU_OP_*, PC_SRC_* : datapath mux / ALU encodings
//   - ctrl_t     : per-state Moore control word
//   - state_ctrl : decode from a state to its control word
package mc_ctrl_pkg;

    localparam int ST_W = 4;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_EXEC      = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_HALT      = 4'd12,
        S_BRANCH_NE = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [1:0] ALU_B_REG    = 2'b00;
    localparam logic [1:0] ALU_B_FOUR   = 2'b01;
    localparam logic [1:0] ALU_B_IMM    = 2'b10;
    localparam logic [1:0] ALU_B_IMM_SH = 2'b11;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // fetch / retire_on_ready mark the states whose outputs also depend
    // on mem_ready in the current cycle; retire marks unconditional retire.
    typedef struct packed {
        logic       branch_ne;
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       fetch;
        logic       retire;
        logic       retire_on_ready;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = ALU_B_FOUR;
                c.fetch     = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_b = ALU_B_IMM_SH;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALU_B_IMM;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_write       = 1'b1;
                c.i_or_d          = 1'b1;
                c.retire_on_ready = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                c.retire     = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALU_B_REG;
                c.alu_op    = ALU_OP_FUNCT;
            end
            S_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                c.retire    = 1'b1;
            end
            S_BRANCH, S_BRANCH_NE: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = ALU_B_REG;
                c.alu_op        = ALU_OP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PC_SRC_ALUOUT;
                c.branch_ne     = (s == S_BRANCH_NE);
                c.retire        = 1'b1;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PC_SRC_JUMP;
                c.retire    = 1'b1;
            end
            S_ADDI_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = ALU_B_IMM;
                c.alu_op    = ALU_OP_ADD;
            end
            S_ADDI_WB: begin
                c.reg_write = 1'b1;
                c.retire    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mc_retire_counter.sv
// mc_retire_counter: retired-instruction counter.
//   clk, rst_n : clock, async active-low reset (count -> 0)
//   inc_i      : increment on the next rising edge
//   count_o    : current count, wraps from all-ones to zero
module mc_retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle MIPS control unit (Moore FSM with memory
// wait states, addi/j support, illegal-opcode trap, retire counter).
//
// Inputs : clk, rst_n (async active-low), opcode (IR[31:26]), mem_ready
// Outputs: datapath controls (pc_write, pc_write_cond, i_or_d, mem_read,
//          mem_write, ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
//          alu_src_b, alu_op, pc_source), instr_done, illegal,
//          instr_count, state_dbg
//
// Build option MC_CTRL_BNE_EN: adds the bne instruction (BRANCH_NE state)
// and the branch_ne output. Without it, opcode 000101 traps as illegal.
//
// state       | meaning
// ------------+---------------------------------------------------
// FETCH       | read instruction at PC, PC+4; waits on mem_ready
// DECODE      | branch target into ALUOut, dispatch on opcode
// MEM_ADDR    | lw/sw effective address
// MEM_RD      | data read; waits on mem_ready
// MEM_WB      | load writeback to rt, retire
// MEM_WR      | data write; waits on mem_ready, retires then
// EXEC        | R-type ALU operation
// R_WB        | R-type writeback to rd, retire
// BRANCH      | beq compare / conditional PC load, retire
// BRANCH_NE   | bne compare / conditional PC load, retire
// JUMP        | jump target into PC, retire
// ADDI_EX     | addi ALU operation
// ADDI_WB     | addi writeback to rt, retire
// HALT        | illegal opcode trap, exit only by reset
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int CNT_W    = 32,
    parameter int STATE_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                pc_write_cond,
    output logic                i_or_d,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
`ifdef MC_CTRL_BNE_EN
    output logic                branch_ne,
`endif
    output logic                instr_done,
    output logic                illegal,
    output logic [CNT_W-1:0]    instr_count,
    output logic [STATE_W-1:0]  state_dbg
);

    state_t     state_q, state_d;
    ctrl_t      ctrl_q;
    logic       illegal_q;
    logic       retire;
    logic [5:0] op6;

    assign op6 = 6'(opcode);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (op6)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
`ifdef MC_CTRL_BNE_EN
                    OP_BNE:       state_d = S_BRANCH_NE;
`endif
                    default:      state_d = S_HALT;
                endcase
            end
            // Only lw/sw can reach MEM_ADDR, so anything but sw is a load.
            S_MEM_ADDR:  state_d = (op6 == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:    if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WR:    if (mem_ready) state_d = S_FETCH;
            S_MEM_WB:    state_d = S_FETCH;
            S_EXEC:      state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_BRANCH_NE: state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_ADDI_EX:   state_d = S_ADDI_WB;
            S_ADDI_WB:   state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_FETCH;
        endcase
    end

    // The control word is decoded from the next state so it is registered
    // alongside the state; its reset value is FETCH's word so the first
    // cycle after reset release already issues the instruction read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            ctrl_q    <= state_ctrl(S_FETCH);
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d);
            if (state_d == S_HALT) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Ungated retire feeds the counter; the counter is itself held in
    // reset while rst_n is low.
    assign retire = ctrl_q.retire | (ctrl_q.retire_on_ready & mem_ready);

    mc_retire_counter #(
        .CNT_W (CNT_W)
    ) u_retire_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (retire),
        .count_o (instr_count)
    );

    // rst_n gating makes every control drop the moment reset asserts,
    // including a write that is mid-handshake.
    assign pc_write      = rst_n & (ctrl_q.pc_write | (ctrl_q.fetch & mem_ready));
    assign ir_write      = rst_n & ctrl_q.fetch & mem_ready;
    assign pc_write_cond = rst_n & ctrl_q.pc_write_cond;
    assign i_or_d        = rst_n & ctrl_q.i_or_d;
    assign mem_read      = rst_n & ctrl_q.mem_read;
    assign mem_write     = rst_n & ctrl_q.mem_write;
    assign mem_to_reg    = rst_n & ctrl_q.mem_to_reg;
    assign reg_dst       = rst_n & ctrl_q.reg_dst;
    assign reg_write     = rst_n & ctrl_q.reg_write;
    assign alu_src_a     = rst_n & ctrl_q.alu_src_a;
    assign alu_src_b     = rst_n ? ctrl_q.alu_src_b : 2'b00;
    assign alu_op        = rst_n ? ctrl_q.alu_op    : 2'b00;
    assign pc_source     = rst_n ? ctrl_q.pc_source : 2'b00;
    assign instr_done    = rst_n & retire;
    assign illegal       = illegal_q;
    assign state_dbg     = STATE_W'(state_q);

`ifdef MC_CTRL_BNE_EN
    assign branch_ne     = rst_n & ctrl_q.branch_ne;
`else
    logic unused_branch_ne;
    assign unused_branch_ne = ctrl_q.branch_ne;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
module tb_mc_control_fsm;
    import mc_ctrl_pkg::*;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [5:0]       opcode = 6'd0;
    logic             mem_ready = 1'b0;
    logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
    logic             ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0]       alu_src_b, alu_op, pc_source;
    logic             instr_done, illegal;
    logic [CNT_W-1:0] instr_count;
    logic [3:0]       state_dbg;
    logic             bne_obs;

    always #5 clk = ~clk;

    mc_control_fsm #(
        .OPCODE_W (6),
        .CNT_W    (CNT_W),
        .STATE_W  (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
`ifdef MC_CTRL_BNE_EN
        .branch_ne     (bne_obs),
`endif
        .instr_done    (instr_done),
        .illegal       (illegal),
        .instr_count   (instr_count),
        .state_dbg     (state_dbg)
    );

`ifndef MC_CTRL_BNE_EN
    assign bne_obs = 1'b0;
`endif

    logic [17:0] obs;
    assign obs = {bne_obs, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
                  ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
                  alu_src_b, alu_op, pc_source, instr_done};

    // Reference model: an instruction is a list of phases, each phase has
    // the control values listed for it in the instruction-sequencing rules.
    typedef enum {P_FETCH, P_DECODE, P_MADDR, P_MRD, P_MWR, P_MWB, P_EXEC,
                  P_RWB, P_BR, P_BNE, P_JUMP, P_AEX, P_AWB, P_HALT} ph_t;
    typedef struct {ph_t ph; bit rdy;} step_t;

    step_t      q[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] m_count = 4'd0;

    function automatic logic [17:0] exp_ctrl(input ph_t ph, input bit rdy);
        logic bne, pw, pwc, iord, mr, mw, irw, m2r, rdst, rw, asa, done;
        logic [1:0] asb, aop, pcs;
        {bne, pw, pwc, iord, mr, mw, irw, m2r, rdst, rw, asa, done} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (ph)
            P_FETCH:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
            P_DECODE: begin asb = 2'b11; end
            P_MADDR:  begin asa = 1; asb = 2'b10; end
            P_MRD:    begin mr = 1; iord = 1; end
            P_MWR:    begin mw = 1; iord = 1; done = rdy; end
            P_MWB:    begin rw = 1; m2r = 1; done = 1; end
            P_EXEC:   begin asa = 1; aop = 2'b10; end
            P_RWB:    begin rw = 1; rdst = 1; done = 1; end
            P_BR:     begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; done = 1; end
            P_BNE:    begin asa = 1; aop = 2'b01; pwc = 1; pcs = 2'b01; done = 1; bne = 1; end
            P_JUMP:   begin pw = 1; pcs = 2'b10; done = 1; end
            P_AEX:    begin asa = 1; asb = 2'b10; end
            P_AWB:    begin rw = 1; done = 1; end
            default:  ;
        endcase
        return {bne, pw, pwc, iord, mr, mw, irw, m2r, rdst, rw, asa,
                asb, aop, pcs, done};
    endfunction

    function automatic state_t st_of(input ph_t ph);
        case (ph)
            P_FETCH:  return S_FETCH;
            P_DECODE: return S_DECODE;
            P_MADDR:  return S_MEM_ADDR;
            P_MRD:    return S_MEM_RD;
            P_MWR:    return S_MEM_WR;
            P_MWB:    return S_MEM_WB;
            P_EXEC:   return S_EXEC;
            P_RWB:    return S_R_WB;
            P_BR:     return S_BRANCH;
            P_BNE:    return S_BRANCH_NE;
            P_JUMP:   return S_JUMP;
            P_AEX:    return S_ADDI_EX;
            P_AWB:    return S_ADDI_WB;
            default:  return S_HALT;
        endcase
    endfunction

    task automatic push(input ph_t ph, input bit rdy);
        step_t s;
        s.ph = ph;
        s.rdy = rdy;
        q.push_back(s);
    endtask

    task automatic build(input logic [5:0] op, input int fw, input int mw);
        q.delete();
        for (int i = 0; i < fw; i++) push(P_FETCH, 1'b0);
        push(P_FETCH, 1'b1);
        push(P_DECODE, 1'($urandom));
        case (op)
            6'b000000: begin push(P_EXEC, 1'($urandom)); push(P_RWB, 1'($urandom)); end
            6'b100011: begin
                push(P_MADDR, 1'($urandom));
                for (int i = 0; i < mw; i++) push(P_MRD, 1'b0);
                push(P_MRD, 1'b1);
                push(P_MWB, 1'($urandom));
            end
            6'b101011: begin
                push(P_MADDR, 1'($urandom));
                for (int i = 0; i < mw; i++) push(P_MWR, 1'b0);
                push(P_MWR, 1'b1);
            end
            6'b000100: push(P_BR, 1'($urandom));
            6'b000010: push(P_JUMP, 1'($urandom));
            6'b001000: begin push(P_AEX, 1'($urandom)); push(P_AWB, 1'($urandom)); end
`ifdef MC_CTRL_BNE_EN
            6'b000101: push(P_BNE, 1'($urandom));
`endif
            default: ;
        endcase
    endtask

    task automatic run_steps(input logic [5:0] op);
        step_t s;
        logic [17:0] e;
        for (int i = 0; i < q.size(); i++) begin
            s = q[i];
            @(negedge clk);
            opcode = (s.ph == P_FETCH) ? 6'($urandom) : op;
            mem_ready = s.rdy;
            #1;
            e = exp_ctrl(s.ph, s.rdy);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL ctrl op=%b ph=%s got=%b exp=%b", op, s.ph.name(), obs, e);
            end
            checks++;
            if (state_dbg !== st_of(s.ph)) begin
                errors++;
                $display("FAIL state op=%b ph=%s got=%0d exp=%0d", op, s.ph.name(), state_dbg, st_of(s.ph));
            end
            checks++;
            if (instr_count !== m_count) begin
                errors++;
                $display("FAIL count ph=%s got=%0d exp=%0d", s.ph.name(), instr_count, m_count);
            end
            checks++;
            if (illegal !== (s.ph == P_HALT)) begin
                errors++;
                $display("FAIL illegal ph=%s got=%b exp=%b", s.ph.name(), illegal, s.ph == P_HALT);
            end
            if (e[0]) m_count = m_count + 4'd1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 18'd0 || state_dbg !== S_FETCH || instr_count !== 4'd0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset ctrl=%b state=%0d count=%0d illegal=%b exp 0/%0d/0/0",
                     obs, state_dbg, instr_count, illegal, S_FETCH);
        end
        m_count = 4'd0;
        repeat (2) @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (obs !== 18'd0 || mem_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=0", obs);
        end
        checks++;
        if (state_dbg !== S_FETCH || instr_count !== 4'd0 || illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_state state=%0d count=%0d illegal=%b exp %0d/0/0",
                     state_dbg, instr_count, illegal, S_FETCH);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_rtype();
        build(6'b000000, 0, 0);
        run_steps(6'b000000);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (instr_count !== 4'd1) begin
            errors++;
            $display("FAIL rtype_count got=%0d exp=1", instr_count);
        end
    endtask

    task automatic test_lw_wait();
        build(6'b100011, 0, 2);
        checks++;
        if (q.size() != 7) begin
            errors++;
            $display("FAIL lw_len got=%0d exp=7", q.size());
        end
        run_steps(6'b100011);
    endtask

    task automatic test_sw_beq();
        do_reset();
        build(6'b101011, 1, 1);
        run_steps(6'b101011);
        build(6'b000100, 0, 0);
        run_steps(6'b000100);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (instr_count !== 4'd2) begin
            errors++;
            $display("FAIL sw_beq_count got=%0d exp=2", instr_count);
        end
    endtask

    task automatic test_illegal(input logic [5:0] op);
        build(op, 0, 0);
        for (int i = 0; i < 20; i++) push(P_HALT, 1'($urandom));
        run_steps(op);
        do_reset();
    endtask

    task automatic test_wrap();
        do_reset();
        for (int n = 0; n < 16; n++) begin
            build(6'b000010, $urandom_range(0, 1), 0);
            run_steps(6'b000010);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        checks++;
        if (instr_count !== 4'd0 || m_count !== 4'd0) begin
            errors++;
            $display("FAIL wrap_count got=%0d exp=0", instr_count);
        end
    endtask

    task automatic test_reset_mid_wr();
        q.delete();
        push(P_FETCH, 1'b1);
        push(P_DECODE, 1'b0);
        push(P_MADDR, 1'b0);
        push(P_MWR, 1'b0);
        run_steps(6'b101011);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mem_write !== 1'b0 || instr_done !== 1'b0 || state_dbg !== S_FETCH || instr_count !== 4'd0) begin
            errors++;
            $display("FAIL mid_wr_reset mem_write=%b done=%b state=%0d count=%0d exp 0/0/%0d/0",
                     mem_write, instr_done, state_dbg, instr_count, S_FETCH);
        end
        m_count = 4'd0;
        mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (state_dbg !== S_FETCH || mem_write !== 1'b0) begin
            errors++;
            $display("FAIL mid_wr_hold state=%0d mem_write=%b exp %0d/0", state_dbg, mem_write, S_FETCH);
        end
        mem_ready = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_bne();
`ifdef MC_CTRL_BNE_EN
        build(6'b000101, 0, 0);
        run_steps(6'b000101);
`else
        test_illegal(6'b000101);
`endif
    endtask

    task automatic test_random();
        logic [5:0] op;
        for (int n = 0; n < 40; n++) begin
`ifdef MC_CTRL_BNE_EN
            case ($urandom_range(0, 6))
`else
            case ($urandom_range(0, 5))
`endif
                0: op = 6'b000000;
                1: op = 6'b100011;
                2: op = 6'b101011;
                3: op = 6'b000100;
                4: op = 6'b000010;
                5: op = 6'b001000;
                default: op = 6'b000101;
            endcase
            build(op, $urandom_range(0, 2), $urandom_range(0, 2));
            run_steps(op);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw_beq();
        test_illegal(6'b111111);
        test_wrap();
        test_reset_mid_wr();
        test_bne();
        test_random();
        test_illegal(6'b011111);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
